// File: rtl/tbird_lamp_seq.sv
// Thunderbird-style tail-light sequencer: LAMPS lamps per side lit inside-out,
// with a step prescaler, a brake overlay and hazard flashing. Outputs are registered.
module tbird_lamp_seq #(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 4
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic             InL,
    input  logic             InR,
    input  logic             InH,
    input  logic             InB,
    output logic [LAMPS-1:0] L,
    output logic [LAMPS-1:0] R
);

    localparam int SW = $clog2(LAMPS + 1);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEFT    = 3'd1,
        RIGHT   = 3'd2,
        HAZ_ON  = 3'd3,
        HAZ_OFF = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    step_q,  step_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [LAMPS-1:0] l_q,     l_d;
    logic [LAMPS-1:0] r_q,     r_d;

    logic             tick;
    logic             haz;
    state_t           req_state;
    logic [SW-1:0]    req_step;
    logic [LAMPS-1:0] therm;

    assign tick = (cnt_q == CW'(TICK_DIV - 1));
    assign haz  = InH | (InL & InR);

    always_comb begin
        req_state = IDLE;
        req_step  = '0;
        if (haz) begin
            req_state = HAZ_ON;
        end else if (InL) begin
            req_state = LEFT;
            req_step  = SW'(1);
        end else if (InR) begin
            req_state = RIGHT;
            req_step  = SW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                state_d = req_state;
                step_d  = req_step;
            end
            LEFT, RIGHT: begin
                // Hazard preempts immediately; a dropped turn request still runs out to step 0.
                if (haz) begin
                    state_d = HAZ_ON;
                    step_d  = '0;
                end else if (tick) begin
                    if (step_q == '0) begin
                        state_d = req_state;
                        step_d  = req_step;
                    end else if (step_q == SW'(LAMPS)) begin
                        step_d = '0;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
            end
            HAZ_ON: begin
                step_d = '0;
                if (tick) state_d = HAZ_OFF;
            end
            HAZ_OFF: begin
                step_d = '0;
                if (tick) state_d = haz ? HAZ_ON : IDLE;
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase
    end

    always_comb begin
        if (state_d != state_q || state_d == IDLE || tick) cnt_d = '0;
        else                                                cnt_d = cnt_q + CW'(1);
    end

    // Lamps follow the next state so a change appears on the edge that samples it;
    // InB feeds the output register directly, which is the brake's one-clock latency.
    always_comb begin
        for (int i = 0; i < LAMPS; i++) therm[i] = (SW'(i) < step_d);
        l_d = '0;
        r_d = '0;
        case (state_d)
            IDLE: begin
                if (InB) begin
                    l_d = '1;
                    r_d = '1;
                end
            end
            LEFT: begin
                l_d = therm;
                if (InB) r_d = '1;
            end
            RIGHT: begin
                r_d = therm;
                if (InB) l_d = '1;
            end
            HAZ_ON: begin
                l_d = '1;
                r_d = '1;
            end
            default: begin
                l_d = '0;
                r_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset_b) begin
        if (reset_b) begin
            state_q <= IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
            l_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            l_q     <= l_d;
            r_q     <= r_d;
        end
    end

    assign L = l_q;
    assign R = r_q;

endmodule

// File: tb/tb_tbird_lamp_seq.sv
// Directed bench for tbird_lamp_seq: LAMPS=3/TICK_DIV=2 main instance plus a
// LAMPS=5/TICK_DIV=1 instance for the parameter sweep.
module tb_tbird_lamp_seq;

    logic       clock;
    logic       reset_b;
    logic       in_l, in_r, in_h, in_b;
    logic [2:0] lamp_l, lamp_r;
    logic       s_inr;
    logic       s_zero;
    logic [4:0] s_l, s_r;

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0] exp_q[$];
    logic [9:0] sweep_q[$];

    tbird_lamp_seq #(.LAMPS(3), .TICK_DIV(2)) u_dut (
        .clock   (clock),
        .reset_b (reset_b),
        .InL     (in_l),
        .InR     (in_r),
        .InH     (in_h),
        .InB     (in_b),
        .L       (lamp_l),
        .R       (lamp_r)
    );

    tbird_lamp_seq #(.LAMPS(5), .TICK_DIV(1)) u_sweep (
        .clock   (clock),
        .reset_b (reset_b),
        .InL     (s_zero),
        .InR     (s_inr),
        .InH     (s_zero),
        .InB     (s_zero),
        .L       (s_l),
        .R       (s_r)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic compare_main(input string tag);
        logic [5:0] e;
        logic [5:0] g;
        e = exp_q.pop_front();
        g = {lamp_l, lamp_r};
        n_tests++;
        assert (g === e) else begin
            n_fail++;
            $error("FAIL %s: got L=%b R=%b, expected L=%b R=%b", tag, g[5:3], g[2:0], e[5:3], e[2:0]);
        end
    endtask

    // Expect a value after the next rising edge.
    task automatic chk_main(input logic [2:0] el, input logic [2:0] er, input string tag);
        exp_q.push_back({el, er});
        @(posedge clock);
        #1;
        compare_main(tag);
    endtask

    // Expect a value without waiting for a clock edge (async reset).
    task automatic chk_now(input logic [2:0] el, input logic [2:0] er, input string tag);
        exp_q.push_back({el, er});
        #1;
        compare_main(tag);
    endtask

    task automatic chk_sweep(input logic [4:0] el, input logic [4:0] er, input string tag);
        logic [9:0] e;
        logic [9:0] g;
        sweep_q.push_back({el, er});
        @(posedge clock);
        #1;
        e = sweep_q.pop_front();
        g = {s_l, s_r};
        n_tests++;
        assert (g === e) else begin
            n_fail++;
            $error("FAIL %s: got L=%b R=%b, expected L=%b R=%b", tag, g[9:5], g[4:0], e[9:5], e[4:0]);
        end
    endtask

    initial begin
        reset_b = 1'b1;
        in_l    = 1'b1;
        in_r    = 1'b0;
        in_h    = 1'b0;
        in_b    = 1'b0;
        s_inr   = 1'b0;
        s_zero  = 1'b0;

        // Reset held with InL high, then release with inputs low
        for (int i = 0; i < 3; i++) chk_main(3'b000, 3'b000, "reset_hold");
        reset_b = 1'b0;
        in_l    = 1'b0;
        chk_main(3'b000, 3'b000, "post_reset");
        chk_main(3'b000, 3'b000, "post_reset");

        // Left sequence, then repeat
        in_l = 1'b1;
        chk_main(3'b001, 3'b000, "left_s1");
        chk_main(3'b001, 3'b000, "left_s1");
        chk_main(3'b011, 3'b000, "left_s2");
        chk_main(3'b011, 3'b000, "left_s2");
        chk_main(3'b111, 3'b000, "left_s3");
        chk_main(3'b111, 3'b000, "left_s3");
        chk_main(3'b000, 3'b000, "left_s0");
        chk_main(3'b000, 3'b000, "left_s0");
        chk_main(3'b001, 3'b000, "left_rep1");
        chk_main(3'b001, 3'b000, "left_rep1");
        chk_main(3'b011, 3'b000, "left_rep2");

        // Drop InL mid-sequence: completes through step 0, then idle
        in_l = 1'b0;
        chk_main(3'b011, 3'b000, "rel_s2");
        chk_main(3'b111, 3'b000, "rel_s3");
        chk_main(3'b111, 3'b000, "rel_s3");
        chk_main(3'b000, 3'b000, "rel_s0");
        chk_main(3'b000, 3'b000, "rel_s0");
        for (int i = 0; i < 3; i++) chk_main(3'b000, 3'b000, "rel_idle");

        // Right sequence preempted by hazard
        in_r = 1'b1;
        chk_main(3'b000, 3'b001, "right_s1");
        chk_main(3'b000, 3'b001, "right_s1");
        chk_main(3'b000, 3'b011, "right_s2");
        in_h = 1'b1;
        chk_main(3'b111, 3'b111, "haz_on");
        chk_main(3'b111, 3'b111, "haz_on");
        chk_main(3'b000, 3'b000, "haz_off");
        chk_main(3'b000, 3'b000, "haz_off");
        chk_main(3'b111, 3'b111, "haz_on2");
        chk_main(3'b111, 3'b111, "haz_on2");
        chk_main(3'b000, 3'b000, "haz_off2");
        in_h = 1'b0;
        in_r = 1'b0;
        chk_main(3'b000, 3'b000, "haz_off2");
        chk_main(3'b000, 3'b000, "haz_exit");
        chk_main(3'b000, 3'b000, "haz_exit");

        // Both turn switches from idle act as hazard
        in_l = 1'b1;
        in_r = 1'b1;
        chk_main(3'b111, 3'b111, "both_on");
        chk_main(3'b111, 3'b111, "both_on");
        chk_main(3'b000, 3'b000, "both_off");
        chk_main(3'b000, 3'b000, "both_off");
        chk_main(3'b111, 3'b111, "both_on2");
        in_l = 1'b0;
        in_r = 1'b0;
        chk_main(3'b111, 3'b111, "both_on2");
        chk_main(3'b000, 3'b000, "both_off2");
        chk_main(3'b000, 3'b000, "both_off2");
        chk_main(3'b000, 3'b000, "both_exit");

        // Brake in idle, with left turn, then under hazard
        in_b = 1'b1;
        chk_main(3'b111, 3'b111, "brk_idle");
        chk_main(3'b111, 3'b111, "brk_idle");
        in_l = 1'b1;
        chk_main(3'b001, 3'b111, "brk_left_s1");
        chk_main(3'b001, 3'b111, "brk_left_s1");
        chk_main(3'b011, 3'b111, "brk_left_s2");
        chk_main(3'b011, 3'b111, "brk_left_s2");
        chk_main(3'b111, 3'b111, "brk_left_s3");
        chk_main(3'b111, 3'b111, "brk_left_s3");
        chk_main(3'b000, 3'b111, "brk_left_s0");
        chk_main(3'b000, 3'b111, "brk_left_s0");
        in_h = 1'b1;
        chk_main(3'b111, 3'b111, "brk_haz_on");
        chk_main(3'b111, 3'b111, "brk_haz_on");
        chk_main(3'b000, 3'b000, "brk_haz_off");
        chk_main(3'b000, 3'b000, "brk_haz_off");
        chk_main(3'b111, 3'b111, "brk_haz_on2");
        in_h = 1'b0;
        in_l = 1'b0;
        in_b = 1'b0;
        chk_main(3'b111, 3'b111, "brk_haz_on2");
        chk_main(3'b000, 3'b000, "brk_haz_off2");
        chk_main(3'b000, 3'b000, "brk_haz_off2");
        chk_main(3'b000, 3'b000, "brk_exit");

        // Reset mid-sequence clears at once; first decode on the edge after release
        in_l = 1'b1;
        chk_main(3'b001, 3'b000, "mid_s1");
        chk_main(3'b001, 3'b000, "mid_s1");
        chk_main(3'b011, 3'b000, "mid_s2");
        reset_b = 1'b1;
        chk_now(3'b000, 3'b000, "mid_async_clear");
        chk_main(3'b000, 3'b000, "mid_reset_hold");
        reset_b = 1'b0;
        chk_main(3'b001, 3'b000, "mid_redecode");
        chk_main(3'b001, 3'b000, "mid_redecode");
        chk_main(3'b011, 3'b000, "mid_redecode_s2");
        in_l    = 1'b0;
        reset_b = 1'b1;
        chk_main(3'b000, 3'b000, "mid_reset2");
        reset_b = 1'b0;
        chk_main(3'b000, 3'b000, "mid_idle");

        // LAMPS=5, TICK_DIV=1: one step per clock
        s_inr = 1'b1;
        chk_sweep(5'b00000, 5'b00001, "sweep_s1");
        chk_sweep(5'b00000, 5'b00011, "sweep_s2");
        chk_sweep(5'b00000, 5'b00111, "sweep_s3");
        chk_sweep(5'b00000, 5'b01111, "sweep_s4");
        chk_sweep(5'b00000, 5'b11111, "sweep_s5");
        chk_sweep(5'b00000, 5'b00000, "sweep_s0");
        chk_sweep(5'b00000, 5'b00001, "sweep_rep");
        s_inr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
